// File: rtl/spi_snapshot_pkg.sv
// Shared sizing helpers for the SPI snapshot readout memory.
// SPI_SNAPSHOT_CKSUM_EN appends a one-byte checksum after the channel data.
package spi_snapshot_pkg;

  typedef logic [7:0] snap_byte_t;

  function automatic int unsigned snap_bpc(input int unsigned ch_width);
    return ch_width / 8;
  endfunction

  function automatic int unsigned snap_data_len(input int unsigned num_ch,
                                                input int unsigned ch_width);
    return num_ch * snap_bpc(ch_width);
  endfunction

  function automatic int unsigned snap_len(input int unsigned num_ch,
                                           input int unsigned ch_width);
`ifdef SPI_SNAPSHOT_CKSUM_EN
    return snap_data_len(num_ch, ch_width) + 1;
`else
    return snap_data_len(num_ch, ch_width);
`endif
  endfunction

  // Address width never drops below one bit, even for a single-byte frame.
  function automatic int unsigned snap_addr_w(input int unsigned num_ch,
                                              input int unsigned ch_width);
    int unsigned l;
    l = snap_len(num_ch, ch_width);
    return (l < 2) ? 1 : 32'($clog2(l));
  endfunction

endpackage

// File: rtl/spi_snapshot_mem_rise.sv
// Rising-edge detector for the SPI byte-advance strobe.
module spi_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) r_d <= 1'b0;
    else     r_d <= d;
  end

  assign rise = d & ~r_d;

endmodule

// File: rtl/spi_snapshot_mem.sv
// Snapshot register of NUM_CH channels served byte-by-byte to an SPI slave.
// SPI_SNAPSHOT_CKSUM_EN adds a modulo-256 byte sum at address DATA_LEN.
module spi_snapshot_mem
  import spi_snapshot_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned CH_WIDTH = 16,
  localparam int unsigned ADDR_W   = snap_addr_w(NUM_CH, CH_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reset_addr,
  input  logic                       incr,
  input  logic                       snap_req,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  output logic [7:0]                 out_byte,
  output logic [ADDR_W-1:0]          addr_out,
  output logic                       frame_active,
  output logic                       snap_ack,
  output logic                       overrun
);

  localparam int unsigned DATA_LEN = snap_data_len(NUM_CH, CH_WIDTH);
  localparam int unsigned LEN      = snap_len(NUM_CH, CH_WIDTH);
  localparam int unsigned SNAP_W   = NUM_CH * CH_WIDTH;

  logic              w_rise;
  logic              w_adv;
  logic              w_capture;
  logic              w_last;
  snap_byte_t        w_byte;
  logic [ADDR_W-1:0] r_addr;
  logic              r_frame_active;
  logic              r_pending;
  logic              r_snap_ack;
  logic              r_overrun;
  logic [SNAP_W-1:0] r_snap;

  spi_rise_detect u_incr_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (incr),
    .rise (w_rise)
  );

  // reset_addr wins over a coincident advance; rst is handled in the register block.
  assign w_adv     = w_rise & ~reset_addr;
  assign w_capture = ~r_frame_active & (snap_req | r_pending);
  assign w_last    = (r_addr == ADDR_W'(LEN - 1));

`ifdef SPI_SNAPSHOT_CKSUM_EN
  snap_byte_t r_cksum;
  snap_byte_t w_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(DATA_LEN); k++) begin
      w_sum = w_sum + ch_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_cksum <= '0;
    else if (w_capture) r_cksum <= w_sum;
  end
`endif

  // Frame address, capture handshake and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr         <= '0;
      r_frame_active <= 1'b0;
      r_pending      <= 1'b0;
      r_snap_ack     <= 1'b0;
      r_overrun      <= 1'b0;
      r_snap         <= '0;
    end else begin
      r_snap_ack <= w_capture;
      if (snap_req && r_pending) r_overrun <= 1'b1;

      if (w_capture) begin
        r_snap    <= ch_data;
        r_pending <= 1'b0;
      end else if (snap_req) begin
        r_pending <= 1'b1;
      end

      if (reset_addr) begin
        r_addr         <= '0;
        r_frame_active <= 1'b0;
      end else if (w_adv) begin
        if (w_last) begin
          r_addr         <= '0;
          r_frame_active <= 1'b0;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_addr == '0) r_frame_active <= 1'b1;
        end
      end
    end
  end

  // Byte k of the snapshot sits at bits [8k +: 8]; channels are packed little-endian.
  always_comb begin
    w_byte = '0;
    for (int k = 0; k < int'(DATA_LEN); k++) begin
      if (r_addr == ADDR_W'(k)) w_byte = r_snap[8*k +: 8];
    end
`ifdef SPI_SNAPSHOT_CKSUM_EN
    if (r_addr == ADDR_W'(DATA_LEN)) w_byte = r_cksum;
`endif
  end

  assign out_byte     = w_byte;
  assign addr_out     = r_addr;
  assign frame_active = r_frame_active;
  assign snap_ack     = r_snap_ack;
  assign overrun      = r_overrun;

endmodule
